// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types, widths and byte-lane helpers for the store buffer
package store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_ADDR_W        = 32;
    localparam int SB_DATA_W        = 32;
    localparam int SB_LANES         = SB_DATA_W / 8;
    localparam int SB_LANE_W        = $clog2(SB_LANES);

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] wdata;
        logic                 byte_op;
    } sb_entry_t;

    // Lanes touched by an access starting at its own address.
    function automatic logic [SB_LANES-1:0] access_lanes(input logic is_byte);
        return is_byte ? SB_LANES'(1) : {SB_LANES{1'b1}};
    endfunction

    // True when byte address a falls inside the access [base .. base+size-1], modulo 2^SB_ADDR_W.
    function automatic logic covers(input logic [SB_ADDR_W-1:0] base,
                                    input logic                 is_byte,
                                    input logic [SB_ADDR_W-1:0] a);
        logic [SB_ADDR_W-1:0] off;
        off = a - base;
        return is_byte ? (off == '0) : (off < SB_ADDR_W'(SB_LANES));
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - MEM-stage request and DataMemory port bundle for the store buffer
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = SB_ADDR_W,
    parameter int DATA_WIDTH    = SB_DATA_W
) ();

    logic                     req_valid;
    logic                     req_write;
    logic                     req_byte;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     stall;
    logic [DATA_WIDTH-1:0]    load_data;
    logic                     empty;
    logic                     mem_WE;
    logic                     mem_addr_mode;
    logic [ADDRESS_WIDTH-1:0] mem_A;
    logic [DATA_WIDTH-1:0]    mem_WD;
    logic [DATA_WIDTH-1:0]    mem_RD;

    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata, mem_RD,
        input  stall, load_data, empty, mem_WE, mem_addr_mode, mem_A, mem_WD
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata, mem_RD,
        output stall, load_data, empty, mem_WE, mem_addr_mode, mem_A, mem_WD
    );

endinterface

// File: rtl/sb_forward_match.sv
// rtl/sb_forward_match.sv - youngest-first overlap search of buffered stores against a load
module sb_forward_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t            entries [DEPTH],
    input  logic [DEPTH-1:0]     valid,
    input  logic [PTR_W-1:0]     head,
    input  logic [SB_ADDR_W-1:0] load_addr,
    input  logic                 load_byte,
    output logic                 hit_full,
    output logic                 hit_partial,
    output logic [SB_DATA_W-1:0] fwd_data
);

    logic [PTR_W-1:0]    idx;
    logic [SB_LANES-1:0] need;
    logic [SB_LANES-1:0] cov;
    logic [SB_LANE_W-1:0] lane;

    // Walk oldest to youngest so the last overlapping entry (the youngest) decides the result.
    always_comb begin
        hit_full    = 1'b0;
        hit_partial = 1'b0;
        fwd_data    = '0;
        idx         = '0;
        cov         = '0;
        lane        = '0;
        need        = access_lanes(load_byte);
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            cov = '0;
            for (int j = 0; j < SB_LANES; j++) begin
                cov[j] = need[j] & covers(entries[idx].addr, entries[idx].byte_op,
                                          load_addr + SB_ADDR_W'(j));
            end
            if (valid[idx] && (cov != '0)) begin
                hit_full    = (cov == need);
                hit_partial = (cov != need);
                fwd_data    = '0;
                for (int j = 0; j < SB_LANES; j++) begin
                    lane = load_addr[SB_LANE_W-1:0] + SB_LANE_W'(j)
                         - entries[idx].addr[SB_LANE_W-1:0];
                    if (cov[j]) begin
                        fwd_data[j*8 +: 8] = entries[idx].wdata[{lane, 3'b000} +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO between MEM stage and DataMemory with load forwarding and port arbitration
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    store_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t            entries [DEPTH];
    sb_entry_t            head_entry;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W:0]       count;
    logic [DEPTH-1:0]     valid;
    logic                 is_load;
    logic                 is_store;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 load_owns;
    logic                 hit_full;
    logic                 hit_partial;
    logic [SB_DATA_W-1:0] fwd_data;

    assign is_load    = bus.req_valid & ~bus.req_write;
    assign is_store   = bus.req_valid &  bus.req_write;
    assign full       = (count == (PTR_W+1)'(DEPTH));
    // A load that only partly overlaps a buffered store yields the port so the head can drain.
    assign load_owns  = is_load & ~hit_partial;
    assign push       = is_store & ~full;
    assign pop        = ~load_owns & (count != '0);
    assign head_entry = entries[head];

    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - head)} < count);
        end
    end

    sb_forward_match #(.DEPTH(DEPTH)) u_match (
        .entries     (entries),
        .valid       (valid),
        .head        (head),
        .load_addr   (bus.req_addr),
        .load_byte   (bus.req_byte),
        .hit_full    (hit_full),
        .hit_partial (hit_partial),
        .fwd_data    (fwd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    // Entry payload needs no reset: validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{addr: bus.req_addr, wdata: bus.req_wdata, byte_op: bus.req_byte};
        end
    end

    always_comb begin
        bus.mem_WE        = 1'b0;
        bus.mem_addr_mode = 1'b0;
        bus.mem_A         = '0;
        bus.mem_WD        = '0;
        if (load_owns) begin
            bus.mem_A         = bus.req_addr;
            bus.mem_addr_mode = bus.req_byte;
        end else if (pop) begin
            bus.mem_WE        = 1'b1;
            bus.mem_A         = head_entry.addr;
            bus.mem_WD        = head_entry.wdata;
            bus.mem_addr_mode = head_entry.byte_op;
        end
    end

    always_comb begin
        bus.stall     = (is_store & full) | (is_load & hit_partial);
        bus.load_data = '0;
        if (is_load) begin
            if (hit_full) begin
                bus.load_data = fwd_data;
            end else if (bus.req_byte) begin
                bus.load_data = {{(SB_DATA_W-8){1'b0}}, bus.mem_RD[7:0]};
            end else begin
                bus.load_data = bus.mem_RD;
            end
        end
    end

    assign bus.empty = (count == '0);

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - table-driven and scoreboarded bench for store_buffer
module tb_store_buffer;
    import store_buffer_pkg::*;

    typedef struct packed {
        logic        v;
        logic        w;
        logic        b;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        st;
        logic [31:0] ld;
        logic        ldc;
        logic        we;
        logic [31:0] a;
        logic        e;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem [0:4095];
    logic       mem_ready = 1'b0;
    vec_t       tbl [$];
    wr_t        exp_q [$];
    int         errors = 0;
    int         checks = 0;
    int         cur_row = -1;

    always #5 clk = ~clk;

    store_buffer_if bus ();

    store_buffer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] pat(input logic [31:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    function automatic logic [31:0] patw(input logic [31:0] a);
        return {pat(a + 32'd3), pat(a + 32'd2), pat(a + 32'd1), pat(a)};
    endfunction

    // DataMemory model: combinational read, posedge write.
    always_comb begin
        bus.mem_RD = '0;
        for (int k = 0; k < 4; k++) begin
            bus.mem_RD[k*8 +: 8] = mem[12'(bus.mem_A + 32'(k))];
        end
        if (bus.mem_addr_mode) begin
            bus.mem_RD[31:8] = '0;
        end
    end

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) begin
                mem[i] <= pat(32'(i));
            end
            mem_ready <= 1'b1;
        end else if (!rst && bus.mem_WE) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 0 || !bus.mem_addr_mode) begin
                    mem[12'(bus.mem_A + 32'(k))] <= bus.mem_WD[k*8 +: 8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, cur_row, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        if (bus.mem_WE) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_unexpected row=%0d actual=%h required=none", cur_row, bus.mem_A);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", bus.mem_A, e.addr);
                chk("write_mode", 32'(bus.mem_addr_mode), 32'(e.is_byte));
                chk("write_data", e.is_byte ? {24'b0, bus.mem_WD[7:0]} : bus.mem_WD,
                                  e.is_byte ? {24'b0, e.data[7:0]}     : e.data);
            end
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic b,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_byte  = b;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    task automatic add(input logic v, input logic w, input logic b,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic st, input logic [31:0] ld, input logic ldc,
                       input logic we, input logic [31:0] a, input logic e);
        vec_t t;
        t = '{v: v, w: w, b: b, addr: addr, wdata: wdata, st: st, ld: ld, ldc: ldc, we: we, a: a, e: e};
        tbl.push_back(t);
    endtask

    task automatic run_row(input vec_t t);
        drive(t.v, t.w, t.b, t.addr, t.wdata);
        if (t.v && t.w) begin
            exp_q.push_back('{addr: t.addr, data: t.wdata, is_byte: t.b});
        end
        @(negedge clk);
        chk("stall", 32'(bus.stall), 32'(t.st));
        if (t.ldc) chk("load_data", bus.load_data, t.ld);
        chk("mem_WE", 32'(bus.mem_WE), 32'(t.we));
        chk("mem_A", bus.mem_A, t.a);
        chk("empty", 32'(bus.empty), 32'(t.e));
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic stalled;
        logic done;
        int   tries;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 32'(bus.stall), 32'h0);
        chk("reset_mem_WE", 32'(bus.mem_WE), 32'h0);
        chk("reset_empty", 32'(bus.empty), 32'h1);
        chk("reset_load_data", bus.load_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //  v     w     b     addr          wdata         st    ld                                  ldc   we    a             e
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,                              1'b1, 1'b0, 32'h0,        1'b1);
        add(1'b1, 1'b1, 1'b0, 32'h10000,    32'hDEADBEEF, 1'b0, 32'h0,                              1'b0, 1'b0, 32'h0,        1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,                              1'b1, 1'b1, 32'h10000,    1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,                              1'b1, 1'b0, 32'h0,        1'b1);
        add(1'b1, 1'b1, 1'b0, 32'h200,      32'h11223344, 1'b0, 32'h0,                              1'b0, 1'b0, 32'h0,        1'b1);
        add(1'b1, 1'b0, 1'b1, 32'h202,      32'h0,        1'b0, 32'h22,                             1'b1, 1'b0, 32'h202,      1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h200,      32'h0,        1'b0, 32'h11223344,                       1'b1, 1'b0, 32'h200,      1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h203,      32'h0,        1'b0, 32'h11,                             1'b1, 1'b0, 32'h203,      1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,                              1'b1, 1'b1, 32'h200,      1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h204,      32'h0,        1'b0, patw(32'h204),                      1'b1, 1'b0, 32'h204,      1'b1);
        add(1'b1, 1'b0, 1'b1, 32'h205,      32'h0,        1'b0, {24'b0, pat(32'h205)},              1'b1, 1'b0, 32'h205,      1'b1);
        add(1'b1, 1'b1, 1'b0, 32'h400,      32'h1,        1'b0, 32'h0,                              1'b0, 1'b0, 32'h0,        1'b1);
        add(1'b1, 1'b1, 1'b0, 32'h400,      32'h2,        1'b0, 32'h0,                              1'b0, 1'b1, 32'h400,      1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h400,      32'h0,        1'b0, 32'h2,                              1'b1, 1'b0, 32'h400,      1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h3FE,      32'h0,        1'b1, 32'h0,                              1'b0, 1'b1, 32'h400,      1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h3FE,      32'h0,        1'b0, {16'h0002, pat(32'h3FF), pat(32'h3FE)}, 1'b1, 1'b0, 32'h3FE, 1'b1);
        add(1'b1, 1'b1, 1'b1, 32'h300,      32'hAB,       1'b0, 32'h0,                              1'b0, 1'b0, 32'h0,        1'b1);
        add(1'b1, 1'b0, 1'b0, 32'h300,      32'h0,        1'b1, 32'h0,                              1'b0, 1'b1, 32'h300,      1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h300,      32'h0,        1'b0, {pat(32'h303), pat(32'h302), pat(32'h301), 8'hAB}, 1'b1, 1'b0, 32'h300, 1'b1);
        add(1'b1, 1'b1, 1'b1, 32'h500,      32'h77,       1'b0, 32'h0,                              1'b0, 1'b0, 32'h0,        1'b1);
        add(1'b1, 1'b0, 1'b1, 32'h500,      32'h0,        1'b0, 32'h77,                             1'b1, 1'b0, 32'h500,      1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h501,      32'h0,        1'b0, {24'b0, pat(32'h501)},              1'b1, 1'b0, 32'h501,      1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,                              1'b1, 1'b1, 32'h500,      1'b0);
        add(1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 32'hA1B2C3D4, 1'b0, 32'h0,                              1'b0, 1'b0, 32'h0,        1'b1);
        add(1'b1, 1'b0, 1'b1, 32'h1,        32'h0,        1'b0, 32'hA1,                             1'b1, 1'b0, 32'h1,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,                              1'b1, 1'b1, 32'hFFFFFFFE, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,                              1'b1, 1'b0, 32'h0,        1'b1);

        foreach (tbl[i]) begin
            cur_row = i;
            run_row(tbl[i]);
        end

        // Five back-to-back stores, each held while stalled; scoreboard checks drain order.
        cur_row = 100;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h700 + 32'(4 * i), 32'h1000 + 32'(i));
            exp_q.push_back('{addr: 32'h700 + 32'(4 * i), data: 32'h1000 + 32'(i), is_byte: 1'b0});
            tries   = 0;
            stalled = 1'b1;
            while (stalled && tries < 8) begin
                @(negedge clk);
                stalled = bus.stall;
                monitor();
                @(posedge clk);
                #1;
                tries++;
            end
            if (stalled) begin
                checks++;
                errors++;
                $display("FAIL store_accept row=%0d actual=stalled required=accepted", cur_row);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            monitor();
            done = bus.empty;
            @(posedge clk);
            #1;
        end
        chk("burst_empty", 32'(done), 32'h1);
        chk("burst_drained", 32'(exp_q.size()), 32'h0);

        // Reset while a store is pending: nothing may reach memory.
        cur_row = 200;
        drive(1'b1, 1'b1, 1'b0, 32'h800, 32'h55667788);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mem_WE", 32'(bus.mem_WE), 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'h1);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
        end
        chk("rst_mem_untouched",
            {mem[12'h803], mem[12'h802], mem[12'h801], mem[12'h800]}, patw(32'h800));
        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
